// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_arbiter_pkg
// Description : Shared encodings and defaults for the main-memory arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int LINE_BEATS_DEFAULT = 4;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_REQ   = 2'd1;
    localparam logic [1:0] ARB_WDATA = 2'd2;
    localparam logic [1:0] ARB_RESP  = 2'd3;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    // A single-beat line still needs a 1-bit counter.
    function automatic int beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_arbiter_if
// Description : Cache-side and memory-side buses of the memory arbiter.
//               master = arbiter view, slave = caches/memory view.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic                  ic_req_valid;
    logic                  ic_req_ready;
    logic [ADDR_W-1:0]     ic_req_addr;
    logic                  ic_resp_valid;
    logic [DATA_W-1:0]     ic_resp_data;

    logic                  dc_req_valid;
    logic                  dc_req_ready;
    logic                  dc_req_rw;
    logic [ADDR_W-1:0]     dc_req_addr;
    logic                  dc_wdata_valid;
    logic                  dc_wdata_ready;
    logic [DATA_W-1:0]     dc_wdata;
    logic [DATA_W/8-1:0]   dc_wmask;
    logic                  dc_resp_valid;
    logic [DATA_W-1:0]     dc_resp_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_rw;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic                  mem_wdata_valid;
    logic                  mem_wdata_ready;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_resp_data;

    modport master (
        input  ic_req_valid, ic_req_addr,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata, dc_wmask,
        input  mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata, mem_wmask
    );

    modport slave (
        output ic_req_valid, ic_req_addr,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_wdata_valid, dc_wdata, dc_wmask,
        output mem_req_ready, mem_wdata_ready, mem_resp_valid, mem_resp_data,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_ready, dc_wdata_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_wdata_valid, mem_wdata, mem_wmask
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_beat_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_arbiter_beat_counter
// Description : Line-transfer beat counter with last-beat flag; wraps to 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_arbiter_beat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int LINE_BEATS = LINE_BEATS_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_inc,
    output logic      o_last
);
    localparam int                 c_cnt_w = beat_cnt_w(LINE_BEATS);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(LINE_BEATS - 1);

    logic [c_cnt_w-1:0] r_count;

    assign o_last = (r_count == c_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_last ? '0 : r_count + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_arbiter
// Description : Shares the main-memory port between I-cache refill and
//               D-cache refill/writeback. Define ARB_RR_EN for round-robin ties.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int LINE_BEATS = LINE_BEATS_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.master bus
);
    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_req_rw;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_mem_req_valid;

    logic              w_idle;
    logic              w_in_wdata;
    logic              w_in_resp;
    logic              w_win_ic;
    logic              w_win_dc;
    logic              w_grant_ic;
    logic              w_grant_dc;
    logic              w_wbeat;
    logic              w_rbeat;
    logic              w_last;
    logic [DATA_W-1:0] w_resp_data;

    assign w_idle     = (r_state == ARB_IDLE) && !reset;
    assign w_in_wdata = (r_state == ARB_WDATA);
    assign w_in_resp  = (r_state == ARB_RESP);

`ifdef ARB_RR_EN
    logic r_last_grant;

    // On a tie, the requester that was not granted last wins.
    assign w_win_dc = bus.dc_req_valid && (!bus.ic_req_valid || (r_last_grant == OWN_IC));
    assign w_win_ic = bus.ic_req_valid && (!bus.dc_req_valid || (r_last_grant == OWN_DC));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= OWN_IC;
        end else if (w_grant_dc) begin
            r_last_grant <= OWN_DC;
        end else if (w_grant_ic) begin
            r_last_grant <= OWN_IC;
        end
    end
`else
    assign w_win_dc = bus.dc_req_valid;
    assign w_win_ic = bus.ic_req_valid && !bus.dc_req_valid;
`endif

    assign w_grant_dc = w_idle && w_win_dc;
    assign w_grant_ic = w_idle && w_win_ic;

    assign w_wbeat = w_in_wdata && bus.dc_wdata_valid && bus.mem_wdata_ready;
    assign w_rbeat = w_in_resp && bus.mem_resp_valid;

    mem_arbiter_beat_counter #(
        .LINE_BEATS (LINE_BEATS)
    ) u_beat_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_state == ARB_IDLE),
        .i_inc   (w_wbeat || w_rbeat),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ARB_IDLE;
            r_owner         <= OWN_IC;
            r_req_rw        <= 1'b0;
            r_req_addr      <= '0;
            r_mem_req_valid <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_dc) begin
                        r_owner         <= OWN_DC;
                        r_req_rw        <= bus.dc_req_rw;
                        r_req_addr      <= bus.dc_req_addr;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ARB_REQ;
                    end else if (w_grant_ic) begin
                        r_owner         <= OWN_IC;
                        r_req_rw        <= 1'b0;
                        r_req_addr      <= bus.ic_req_addr;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= r_req_rw ? ARB_WDATA : ARB_RESP;
                    end
                end
                ARB_WDATA: begin
                    if (w_wbeat && w_last) begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_RESP: begin
                    if (w_rbeat && w_last) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.ic_req_ready    = w_grant_ic;
    assign bus.dc_req_ready    = w_grant_dc;

    assign bus.mem_req_valid   = r_mem_req_valid;
    assign bus.mem_req_rw      = r_req_rw;
    assign bus.mem_req_addr    = r_req_addr;

    // Write data is a pure pass-through; only the handshake is gated by state.
    assign bus.mem_wdata_valid = w_in_wdata && bus.dc_wdata_valid;
    assign bus.dc_wdata_ready  = w_in_wdata && bus.mem_wdata_ready;
    assign bus.mem_wdata       = bus.dc_wdata;
    assign bus.mem_wmask       = bus.dc_wmask;

    assign w_resp_data         = bus.mem_resp_data;
    assign bus.ic_resp_valid   = w_rbeat && (r_owner == OWN_IC);
    assign bus.dc_resp_valid   = w_rbeat && (r_owner == OWN_DC);
    assign bus.ic_resp_data    = w_resp_data;
    assign bus.dc_resp_data    = w_resp_data;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter (4-beat lines).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) bus ();

    mem_arbiter #(
        .ADDR_W     (28),
        .DATA_W     (128),
        .LINE_BEATS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Single requester; checks the grant and the registered command.
    task automatic grant(input bit to_dc, input bit rw, input logic [27:0] addr);
        if (to_dc) begin
            bus.dc_req_valid = 1'b1;
            bus.dc_req_rw    = rw;
            bus.dc_req_addr  = addr;
        end else begin
            bus.ic_req_valid = 1'b1;
            bus.ic_req_addr  = addr;
        end
        #1;
        check("grant_ic", bus.ic_req_ready, !to_dc);
        check("grant_dc", bus.dc_req_ready, to_dc);
        tick();
        bus.ic_req_valid = 1'b0;
        bus.dc_req_valid = 1'b0;
        check("req_valid", bus.mem_req_valid, 1'b1);
        check("req_addr", bus.mem_req_addr, addr);
        check("req_rw", bus.mem_req_rw, rw);
    endtask

    // From REQ: stall, accept, then 4 read beats with a one-cycle gap after beat 2.
    task automatic read_burst(input bit to_dc, input int n_stall, input logic [127:0] base);
        for (int s = 0; s < n_stall; s++) begin
            tick();
            check("req_hold", bus.mem_req_valid, 1'b1);
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = base + 128'(i);
            #1;
            check("ic_resp_valid", bus.ic_resp_valid, !to_dc);
            check("dc_resp_valid", bus.dc_resp_valid, to_dc);
            check("resp_data", to_dc ? bus.dc_resp_data : bus.ic_resp_data, base + 128'(i));
            check("no_grant_mid", {bus.ic_req_ready, bus.dc_req_ready}, 2'b00);
            check("in_resp", dut.r_state, ARB_RESP);
            tick();
            if (i == 1) begin
                bus.mem_resp_valid = 1'b0;
                #1;
                check("gap_resp", {bus.ic_resp_valid, bus.dc_resp_valid}, 2'b00);
                tick();
            end
        end
        bus.mem_resp_valid = 1'b0;
        #1;
        check("idle_after_read", dut.r_state, ARB_IDLE);
        check("cnt_after_read", dut.u_beat_cnt.r_count, 0);
    endtask

    initial begin
        logic [2:0] tie_exp;
        int         k;
        int         cyc;

        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        bus.ic_req_valid    = 1'b0;
        bus.ic_req_addr     = '0;
        bus.dc_req_valid    = 1'b0;
        bus.dc_req_rw       = 1'b0;
        bus.dc_req_addr     = '0;
        bus.dc_wdata_valid  = 1'b0;
        bus.dc_wdata        = '0;
        bus.dc_wmask        = '0;
        bus.mem_req_ready   = 1'b0;
        bus.mem_wdata_ready = 1'b0;
        bus.mem_resp_valid  = 1'b0;
        bus.mem_resp_data   = '0;

        // Reset state, with a requester already waiting.
        repeat (3) @(posedge clk);
        #1;
        bus.ic_req_valid = 1'b1;
        #1;
        check("rst_ic_ready", bus.ic_req_ready, 1'b0);
        check("rst_req_valid", bus.mem_req_valid, 1'b0);
        check("rst_req_addr", bus.mem_req_addr, 0);
        check("rst_state", dut.r_state, ARB_IDLE);
        bus.ic_req_valid = 1'b0;
        reset = 1'b0;
        tick();

        // I-cache read with a 2-cycle command stall.
        grant(1'b0, 1'b0, 28'h0000100);
        read_burst(1'b0, 2, 128'hA0);

        // Stray response beat in IDLE.
        bus.mem_resp_valid = 1'b1;
        #1;
        check("stray_idle_resp", {bus.ic_resp_valid, bus.dc_resp_valid}, 2'b00);
        tick();
        check("stray_idle_cnt", dut.u_beat_cnt.r_count, 0);
        bus.mem_resp_valid = 1'b0;

        // D-cache write, stray response in REQ, toggling write-ready.
        grant(1'b1, 1'b1, 28'h0000200);
        bus.mem_resp_valid = 1'b1;
        #1;
        check("stray_req_resp", {bus.ic_resp_valid, bus.dc_resp_valid}, 2'b00);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        check("stray_req_cnt", dut.u_beat_cnt.r_count, 0);
        check("in_wdata", dut.r_state, ARB_WDATA);
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            bus.dc_wdata_valid  = 1'b1;
            bus.dc_wdata        = 128'hB0 + 128'(k);
            bus.dc_wmask        = 16'hFFFF;
            bus.mem_wdata_ready = cyc[0];
            #1;
            check("wvalid", bus.mem_wdata_valid, 1'b1);
            check("wdata", bus.mem_wdata, 128'hB0 + 128'(k));
            check("wmask", bus.mem_wmask, 16'hFFFF);
            check("wready", bus.dc_wdata_ready, cyc[0]);
            check("wr_no_resp", {bus.ic_resp_valid, bus.dc_resp_valid}, 2'b00);
            if (cyc[0]) k++;
            tick();
            cyc++;
        end
        check("wbeats", k, 4);
        check("wcycles", cyc, 8);
        check("idle_after_write", dut.r_state, ARB_IDLE);
        bus.mem_wdata_ready = 1'b1;
        #1;
        check("idle_wvalid", bus.mem_wdata_valid, 1'b0);
        check("idle_wready", bus.dc_wdata_ready, 1'b0);
        bus.dc_wdata_valid  = 1'b0;
        bus.mem_wdata_ready = 1'b0;

        // Three consecutive ties, starting from reset.
        do_reset();
`ifdef ARB_RR_EN
        tie_exp = 3'b101;
`else
        tie_exp = 3'b111;
`endif
        for (int t = 0; t < 3; t++) begin
            bus.ic_req_valid = 1'b1;
            bus.ic_req_addr  = 28'h0000300;
            bus.dc_req_valid = 1'b1;
            bus.dc_req_rw    = 1'b0;
            bus.dc_req_addr  = 28'h0000400;
            #1;
            check("tie_dc", bus.dc_req_ready, tie_exp[2-t]);
            check("tie_ic", bus.ic_req_ready, !tie_exp[2-t]);
            tick();
            bus.ic_req_valid = 1'b0;
            bus.dc_req_valid = 1'b0;
            check("tie_addr", bus.mem_req_addr, tie_exp[2-t] ? 28'h0000400 : 28'h0000300);
            read_burst(tie_exp[2-t], 0, 128'hD0);
        end

        // I-cache request held during a D-cache read burst.
        grant(1'b1, 1'b0, 28'h0000500);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 28'h0000680;
        read_burst(1'b1, 1, 128'hE0);
        check("ic_wait_grant", bus.ic_req_ready, 1'b1);
        tick();
        bus.ic_req_valid = 1'b0;
        check("ic_wait_req", bus.mem_req_valid, 1'b1);
        check("ic_wait_addr", bus.mem_req_addr, 28'h0000680);
        read_burst(1'b0, 0, 128'hF0);

        // Reset after beat 2 of a D-cache read.
        grant(1'b1, 1'b0, 28'h0000600);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 128'h60 + 128'(i);
            tick();
        end
        check("pre_rst_cnt", dut.u_beat_cnt.r_count, 2);
        bus.dc_req_valid = 1'b1;
        reset = 1'b1;
        #1;
        check("mid_rst_state", dut.r_state, ARB_IDLE);
        check("mid_rst_cnt", dut.u_beat_cnt.r_count, 0);
        check("mid_rst_req_valid", bus.mem_req_valid, 1'b0);
        check("mid_rst_req_addr", bus.mem_req_addr, 0);
        check("mid_rst_resp", {bus.ic_resp_valid, bus.dc_resp_valid}, 2'b00);
        check("mid_rst_ready", bus.dc_req_ready, 1'b0);
        tick();
        reset              = 1'b0;
        bus.dc_req_valid   = 1'b0;
        bus.mem_resp_valid = 1'b0;
        grant(1'b0, 1'b0, 28'h0000700);
        read_burst(1'b0, 0, 128'h10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
